// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register_file write port among writeback sources.
// The winning write is registered; also keeps a saturating contention counter.
module regfile_wb_arbiter #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int N_REQ  = 3,
    parameter int GID_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*XLEN-1:0]   req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    wb_stall,
    output logic                    we,
    output logic [ADDR_W-1:0]       waddr_rd,
    output logic [XLEN-1:0]         wdata_rd,
    output logic [GID_W-1:0]        grant_id,
    output logic [CNT_W-1:0]        conflict_cnt
);

    logic [GID_W-1:0]  rr_ptr;
    logic [GID_W:0]    scan_idx;
    logic              gnt_found;
    logic [GID_W-1:0]  gnt_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]   sel_data;
    logic [2:0]        valid_cnt;
    logic              contend;

    // Scan from rr_ptr upward, wrapping at N_REQ; first valid source wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        if (!rst && !wb_stall) begin
            for (int k = 0; k < N_REQ; k++) begin
                scan_idx = {1'b0, rr_ptr} + (GID_W+1)'(k);
                if (scan_idx >= (GID_W+1)'(N_REQ))
                    scan_idx = scan_idx - (GID_W+1)'(N_REQ);
                for (int i = 0; i < N_REQ; i++) begin
                    if (!gnt_found && req_valid[i] && scan_idx == (GID_W+1)'(i)) begin
                        gnt_found = 1'b1;
                        gnt_idx   = GID_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_found && gnt_idx == GID_W'(i)) begin
                req_ready[i] = 1'b1;
                sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
                sel_data     = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < N_REQ; i++)
            valid_cnt = valid_cnt + {2'b00, req_valid[i]};
        contend = (valid_cnt >= 3'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we           <= 1'b0;
            waddr_rd     <= '0;
            wdata_rd     <= '0;
            grant_id     <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt_found) begin
                // x0 writes are consumed but never enabled on the port
                we       <= (sel_addr != '0);
                waddr_rd <= sel_addr;
                wdata_rd <= sel_data;
                grant_id <= gnt_idx;
                rr_ptr   <= (gnt_idx == GID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                we <= 1'b0;
            end
            if (contend && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule
